dly_tap_controller: RTL and testbench

Sequencing controller for a bank of NUM_DLY programmable delay lines whose 6-bit tap values reach the fabric through the delay-value readback mux. It accepts load, increment, decrement and read commands over a valid/ready interface, and pulses the per-line DLY_LOAD or DLY_ADJ/DLY_INCDEC controls. It waits a settle time, then drives DLY_ADDR to the mux and reads back DLY_TAP_VALUE. It keeps a shadow copy of every tap value and flags any readback that does not match the shadow.

---
 rtl/dly_tap_if.sv | 24 ++
 rtl/dly_tap_controller.sv | 154 +++++++++++++++
 tb/tb_dly_tap_controller.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/dly_tap_if.sv
// Command/response handshake bundle between a sequencer and the delay-tap controller.
interface dly_tap_if #(
  parameter int TAP_W = 6
);
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [1:0]       CMD_OP;
  logic [4:0]       CMD_ADDR;
  logic [TAP_W-1:0] CMD_DATA;
  logic             RSP_VALID;
  logic             RSP_READY;
  logic [TAP_W-1:0] RSP_DATA;
  logic             RSP_ERR;

  modport master (
    output CMD_VALID, CMD_OP, CMD_ADDR, CMD_DATA, RSP_READY,
    input  CMD_READY, RSP_VALID, RSP_DATA, RSP_ERR
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_ADDR, CMD_DATA, RSP_READY,
    output CMD_READY, RSP_VALID, RSP_DATA, RSP_ERR
  );
endinterface

// File: rtl/dly_tap_controller.sv
// Sequences load/adjust/read commands onto a bank of delay lines, keeps a shadow of
// every tap value and verifies it against the readback mux after a settle delay.
module dly_tap_controller #(
  parameter int NUM_DLY       = 20,
  parameter int TAP_W         = 6,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               CLK,
  input  logic               RST,
  dly_tap_if.slave           bus,
  output logic [NUM_DLY-1:0] DLY_LOAD,
  output logic [TAP_W-1:0]   DLY_LOAD_VAL,
  output logic [NUM_DLY-1:0] DLY_ADJ,
  output logic [NUM_DLY-1:0] DLY_INCDEC,
  output logic [4:0]         DLY_ADDR,
  input  logic [TAP_W-1:0]   DLY_TAP_VALUE
);

  localparam logic [1:0]       OP_LOAD   = 2'b00;
  localparam logic [1:0]       OP_INC    = 2'b01;
  localparam logic [1:0]       OP_DEC    = 2'b10;
  localparam logic [TAP_W-1:0] MAX_TAP   = '1;
  localparam logic [4:0]       LAST_ADDR = 5'(NUM_DLY - 1);
  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, READBACK, RESP} state_t;

  state_t state, state_next;

  logic [TAP_W-1:0]   shadow [NUM_DLY];
  logic [3:0]         settle_cnt;
  logic               cmd_ready;
  logic               rsp_valid;
  logic               rsp_err;
  logic [TAP_W-1:0]   rsp_data;

  logic               accept;
  logic               addr_ok;
  logic               sample;
  logic               rsp_done;
  logic [TAP_W-1:0]   cur_tap;
  logic [NUM_DLY-1:0] cmd_onehot;
  logic               mismatch;

  function automatic logic [TAP_W-1:0] sat_inc(input logic [TAP_W-1:0] v);
    return (v == MAX_TAP) ? v : v + 1'b1;
  endfunction

  function automatic logic [TAP_W-1:0] sat_dec(input logic [TAP_W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  assign addr_ok    = (bus.CMD_ADDR <= LAST_ADDR);
  assign cur_tap    = shadow[bus.CMD_ADDR];
  assign cmd_onehot = NUM_DLY'(1) << bus.CMD_ADDR;
  assign mismatch   = (DLY_TAP_VALUE != shadow[DLY_ADDR]);

  assign bus.CMD_READY = cmd_ready;
  assign bus.RSP_VALID = rsp_valid;
  assign bus.RSP_DATA  = rsp_data;
  assign bus.RSP_ERR   = rsp_err;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    sample     = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      IDLE: begin
        accept = cmd_ready && bus.CMD_VALID;
        if (accept) state_next = addr_ok ? ISSUE : RESP;
      end
      ISSUE:  state_next = SETTLE;
      SETTLE: if (settle_cnt == '0) state_next = READBACK;
      READBACK: begin
        sample     = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        rsp_done = bus.RSP_READY;
        if (rsp_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pulses are registered at the accept edge so they are visible for exactly the ISSUE cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cmd_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_data     <= '0;
      settle_cnt   <= '0;
      DLY_LOAD     <= '0;
      DLY_LOAD_VAL <= '0;
      DLY_ADJ      <= '0;
      DLY_INCDEC   <= '0;
      DLY_ADDR     <= '0;
      for (int i = 0; i < NUM_DLY; i++) shadow[i] <= '0;
    end else begin
      cmd_ready <= (state_next == IDLE);
      DLY_LOAD  <= '0;
      DLY_ADJ   <= '0;

      if (accept) begin
        if (addr_ok) begin
          DLY_ADDR <= bus.CMD_ADDR;
          case (bus.CMD_OP)
            OP_LOAD: begin
              DLY_LOAD                <= cmd_onehot;
              DLY_LOAD_VAL            <= bus.CMD_DATA;
              shadow[bus.CMD_ADDR]    <= bus.CMD_DATA;
            end
            OP_INC: if (cur_tap != MAX_TAP) begin
              DLY_ADJ                 <= cmd_onehot;
              DLY_INCDEC              <= DLY_INCDEC | cmd_onehot;
              shadow[bus.CMD_ADDR]    <= sat_inc(cur_tap);
            end
            OP_DEC: if (cur_tap != '0) begin
              DLY_ADJ                 <= cmd_onehot;
              DLY_INCDEC              <= DLY_INCDEC & ~cmd_onehot;
              shadow[bus.CMD_ADDR]    <= sat_dec(cur_tap);
            end
            default: ;
          endcase
        end else begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_data  <= '0;
        end
      end

      if (state == ISSUE)                      settle_cnt <= SETTLE_LD;
      else if (state == SETTLE && settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;

      // A mismatching readback resynchronises the shadow to the hardware.
      if (sample) begin
        rsp_valid <= 1'b1;
        rsp_data  <= DLY_TAP_VALUE;
        rsp_err   <= mismatch;
        if (mismatch) shadow[DLY_ADDR] <= DLY_TAP_VALUE;
      end

      if (rsp_done) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dly_tap_controller.sv
// Directed bench for dly_tap_controller with a behavioural delay-line bank and readback mux.
module tb_dly_tap_controller;
  localparam int NUM_DLY       = 20;
  localparam int TAP_W         = 6;
  localparam int SETTLE_CYCLES = 2;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic [NUM_DLY-1:0] DLY_LOAD, DLY_ADJ, DLY_INCDEC;
  logic [TAP_W-1:0]   DLY_LOAD_VAL, DLY_TAP_VALUE;
  logic [4:0]         DLY_ADDR;

  dly_tap_if #(.TAP_W(TAP_W)) bus ();

  dly_tap_controller #(
    .NUM_DLY(NUM_DLY), .TAP_W(TAP_W), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bus),
    .DLY_LOAD(DLY_LOAD), .DLY_LOAD_VAL(DLY_LOAD_VAL), .DLY_ADJ(DLY_ADJ),
    .DLY_INCDEC(DLY_INCDEC), .DLY_ADDR(DLY_ADDR), .DLY_TAP_VALUE(DLY_TAP_VALUE)
  );

  always #5 CLK = ~CLK;

  // Behavioural delay lines: they reset with the controller and follow its pulses.
  logic [TAP_W-1:0] taps [32];
  logic             force_en = 1'b0;

  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) taps[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_DLY; i++) begin
        if (DLY_LOAD[i])     taps[i] <= DLY_LOAD_VAL;
        else if (DLY_ADJ[i]) taps[i] <= DLY_INCDEC[i] ? taps[i] + 1'b1 : taps[i] - 1'b1;
      end
    end
  end

  assign DLY_TAP_VALUE = (force_en && DLY_ADDR == 5'd7) ? 6'd9 : taps[DLY_ADDR];

  int checks = 0;
  int errors = 0;

  logic [NUM_DLY-1:0] p_load, p_adj, p_incdec, q_load, q_adj;
  logic [TAP_W-1:0]   p_val, r_data;
  logic               r_err;
  int                 lat;
  logic               seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered and left at a falling edge; lat = rising edges after the accept edge until RSP_VALID.
  task automatic run_cmd(input logic [1:0] op, input logic [4:0] addr, input logic [TAP_W-1:0] data);
    int n;
    n = 0;
    while (bus.CMD_READY !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    bus.CMD_VALID = 1'b1;
    bus.CMD_OP    = op;
    bus.CMD_ADDR  = addr;
    bus.CMD_DATA  = data;
    @(posedge CLK);
    @(negedge CLK);
    bus.CMD_VALID = 1'b0;
    p_load   = DLY_LOAD;
    p_adj    = DLY_ADJ;
    p_incdec = DLY_INCDEC;
    p_val    = DLY_LOAD_VAL;
    q_load   = '0;
    q_adj    = '0;
    lat      = 0;
    while (bus.RSP_VALID !== 1'b1 && lat < 30) begin
      @(posedge CLK);
      @(negedge CLK);
      lat++;
      if (lat == 1) begin
        q_load = DLY_LOAD;
        q_adj  = DLY_ADJ;
      end
    end
    r_data = bus.RSP_DATA;
    r_err  = bus.RSP_ERR;
  endtask

  task automatic ack();
    bus.RSP_READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.RSP_READY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.CMD_VALID = 1'b0;
    bus.CMD_OP    = '0;
    bus.CMD_ADDR  = '0;
    bus.CMD_DATA  = '0;
    bus.RSP_READY = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", {bus.CMD_READY, bus.RSP_VALID, bus.RSP_ERR, bus.RSP_DATA,
                          DLY_LOAD, DLY_ADJ, DLY_INCDEC, DLY_ADDR}, '0);
    RST = 1'b0;
    @(negedge CLK);
    chk("ready_after_reset", bus.CMD_READY, 1);

    // Load addr 5 with 42
    run_cmd(2'b00, 5'd5, 6'd42);
    chk("load5_pulse", p_load, 64'd1 << 5);
    chk("load5_val", p_val, 42);
    chk("load5_adj_quiet", p_adj, 0);
    chk("load5_one_cycle", q_load, 0);
    chk("load5_latency", lat, 4);
    chk("load5_data", r_data, 42);
    chk("load5_err", r_err, 0);
    chk("load5_addr", DLY_ADDR, 5);
    ack();

    // Saturation at both ends
    run_cmd(2'b00, 5'd19, 6'd63);
    ack();
    run_cmd(2'b01, 5'd19, 6'd0);
    chk("inc_sat_nopulse", p_adj, 0);
    chk("inc_sat_data", r_data, 63);
    chk("inc_sat_err", r_err, 0);
    ack();
    run_cmd(2'b00, 5'd0, 6'd0);
    ack();
    run_cmd(2'b10, 5'd0, 6'd0);
    chk("dec_sat_nopulse", p_adj, 0);
    chk("dec_sat_data", r_data, 0);
    chk("dec_sat_err", r_err, 0);
    ack();

    // Increment and decrement on addr 3
    run_cmd(2'b00, 5'd3, 6'd10);
    ack();
    for (int k = 1; k <= 3; k++) begin
      run_cmd(2'b01, 5'd3, 6'd0);
      chk("inc3_pulse", p_adj, 64'd1 << 3);
      chk("inc3_dir", p_incdec[3], 1);
      chk("inc3_one_cycle", q_adj, 0);
      chk("inc3_data", r_data, 10 + k);
      ack();
    end
    run_cmd(2'b10, 5'd3, 6'd0);
    chk("dec3_pulse", p_adj, 64'd1 << 3);
    chk("dec3_dir", p_incdec[3], 0);
    chk("dec3_data", r_data, 12);
    chk("dec3_err", r_err, 0);
    ack();

    // Bad addresses: response is visible in the cycle right after accept
    run_cmd(2'b11, 5'd20, 6'd0);
    chk("bad20_latency", lat, 0);
    chk("bad20_nopulse", {p_load, p_adj}, 0);
    chk("bad20_resp", {r_err, r_data}, {1'b1, 6'd0});
    chk("bad20_addr_kept", DLY_ADDR, 3);
    ack();
    run_cmd(2'b00, 5'd31, 6'd17);
    chk("bad31_latency", lat, 0);
    chk("bad31_nopulse", {p_load, p_adj}, 0);
    chk("bad31_resp", {r_err, r_data}, {1'b1, 6'd0});
    chk("bad31_addr_kept", DLY_ADDR, 3);
    ack();

    // Readback mismatch on addr 7 and response hold
    run_cmd(2'b00, 5'd7, 6'd4);
    chk("load7_err", r_err, 0);
    ack();
    force_en = 1'b1;
    run_cmd(2'b11, 5'd7, 6'd0);
    chk("mism7_err", r_err, 1);
    chk("mism7_data", r_data, 9);
    bus.CMD_VALID = 1'b1;
    bus.CMD_OP    = 2'b00;
    bus.CMD_ADDR  = 5'd2;
    bus.CMD_DATA  = 6'd50;
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      chk("hold_stable", {bus.RSP_VALID, bus.RSP_ERR, bus.RSP_DATA, bus.CMD_READY, DLY_LOAD},
          {1'b1, 1'b1, 6'd9, 1'b0, 20'd0});
    end
    bus.CMD_VALID = 1'b0;
    ack();
    run_cmd(2'b11, 5'd7, 6'd0);
    chk("reread7_err", r_err, 0);
    chk("reread7_data", r_data, 9);
    ack();
    force_en = 1'b0;

    // Reset during SETTLE of a load to addr 11
    bus.CMD_VALID = 1'b1;
    bus.CMD_OP    = 2'b00;
    bus.CMD_ADDR  = 5'd11;
    bus.CMD_DATA  = 6'd33;
    @(posedge CLK);
    @(negedge CLK);
    bus.CMD_VALID = 1'b0;
    chk("rst_case_pulse", DLY_LOAD, 64'd1 << 11);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_midop_outputs", {bus.CMD_READY, bus.RSP_VALID, bus.RSP_ERR, bus.RSP_DATA,
                              DLY_LOAD, DLY_ADJ, DLY_INCDEC, DLY_ADDR, DLY_LOAD_VAL}, '0);
    RST = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      if (bus.RSP_VALID !== 1'b0) seen = 1'b1;
    end
    chk("no_rsp_after_abort", seen, 0);
    run_cmd(2'b11, 5'd11, 6'd0);
    chk("rst11_latency", lat, 4);
    chk("rst11_data", r_data, 0);
    chk("rst11_err", r_err, 0);
    ack();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
